programmable_clock_divider: RTL and testbench
=============================================

PROGRAMMABLE_CLOCK_DIVIDER -- requirements
Module: programmable_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter DIV_WIDTH, default 11: width of each channel's divisor and counter.
REQ-003 Parameter DEFAULT_DIV, default 2047: divisor loaded into every channel at reset.
REQ-004 Parameter DEFAULT_EN, default 1: channel enable state at reset.
REQ-005 The module SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port IN_50Mhz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-007 Port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port CFG_WE, input, 1 bit: configuration write strobe, one cycle per write.
REQ-009 Port CFG_CH, input, clog2(NUM_CH) bits (minimum 1): target channel index.
REQ-010 Port CFG_DIV, input, DIV_WIDTH bits: new divisor.
REQ-011 Port CFG_MODE, input, 1 bit: 0 = toggle (50% square), 1 = pulse (one-cycle strobe).
REQ-012 Port CFG_EN, input, 1 bit: new channel enable.
REQ-013 Port OUT, output, NUM_CH bits: divided output per channel, registered.
REQ-014 Port TICK, output, NUM_CH bits: one-cycle strobe at each terminal count, registered.
REQ-015 Port PENDING, output, NUM_CH bits: a written configuration awaits its apply point.

Function
REQ-016 Each enabled channel's counter SHALL count 0..DIV, then return to 0; the cycle it equals DIV is its terminal count (TC).
REQ-017 At TC, TICK[i] SHALL be high for exactly the following cycle.
REQ-018 Toggle mode: OUT[i] SHALL invert at each TC, giving a period of 2*(DIV+1) clocks.
REQ-019 Pulse mode: OUT[i] SHALL equal TICK[i], giving a period of DIV+1 clocks.
REQ-020 DIV=0 SHALL be legal: TC every cycle, so toggle mode yields IN_50Mhz/2.
REQ-021 Each channel SHALL hold an active config (DIV, MODE, EN) and a shadow config.
REQ-022 A write with CFG_CH >= NUM_CH SHALL be ignored with no state change.
REQ-023 A write with CFG_EN=0, or to a currently disabled channel, SHALL reach the active config on the next edge; PENDING[i] stays 0.
REQ-024 Any other write SHALL load the shadow config and set PENDING[i] on the next edge.
REQ-025 At TC with PENDING[i]=1, the shadow SHALL load into the active config and PENDING[i] SHALL clear, giving glitch-free divisor and mode changes.
REQ-026 Simultaneous write and TC on the same channel: the write SHALL win the shadow, PENDING[i] SHALL be 1 afterwards, and the active config SHALL take the previous shadow if one was pending.
REQ-027 A second write while PENDING[i]=1 SHALL overwrite the shadow.
REQ-028 A disabled channel SHALL hold counter=0, OUT[i]=0, TICK[i]=0 from the cycle after disable.
REQ-029 After enable, the first TC SHALL occur DIV+1 clocks after the enabling edge.
REQ-030 A mode change at TC SHALL clear OUT[i] to 0 in that same update.
REQ-031 Channels SHALL be fully independent; a write to one SHALL not disturb another's counter.

Reset
REQ-032 RESET asserted SHALL immediately force: counters 0, OUT 0, TICK 0, PENDING 0, active DIV=DEFAULT_DIV, MODE=toggle, EN=DEFAULT_EN, shadow equal to active.
REQ-033 Reset mid-period SHALL discard any pending config; counting SHALL restart from 0 on the first edge after release.

Structure
REQ-034 A shared package SHALL hold the mode constants (MODE_TOGGLE=0, MODE_PULSE=1) and the channel config typedef {en, mode, div}.
REQ-035 Per-channel logic SHALL be a sub-module divider_channel, generated NUM_CH times; the top level decodes CFG_CH only.

Verification
REQ-036 Reset release with defaults -> OUT[0] toggles every 2048 clocks; TICK[0] pulses every 2048 clocks.
REQ-037 Write ch1 DIV=3 toggle while enabled -> PENDING[1]=1 until the next TC of the old divisor, then OUT[1] has an 8-clock period with no short pulse.
REQ-038 Write ch2 DIV=0 pulse -> OUT[2] and TICK[2] high every cycle after the apply point.
REQ-039 Write ch0 EN=0 mid-count -> OUT[0]=0 and TICK[0]=0 next cycle; re-enable with DIV=4 -> first TICK[0] 5 clocks later.
REQ-040 Write coinciding with a TC, and a write with CFG_CH=NUM_CH -> behaviour per REQ-026; the out-of-range write changes nothing.
REQ-041 Assert RESET while PENDING[3]=1 mid-period -> all outputs 0 immediately; ch3 resumes at DEFAULT_DIV.

Source files
------------

// File: rtl/programmable_clock_divider_pkg.sv
// Shared mode constants and channel configuration record for the clock divider.
package programmable_clock_divider_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Divisor field is sized for the widest supported DIV_WIDTH; channels zero-extend.
  localparam int CFG_DIV_W = 32;

  typedef struct packed {
    logic                 en;
    logic                 mode;
    logic [CFG_DIV_W-1:0] div;
  } ch_cfg_t;

endpackage

// File: rtl/programmable_clock_divider_channel.sv
// One divider channel: counter, terminal-count strobe, and active/shadow config
// so divisor and mode changes land only on a terminal count.
module divider_channel
  import programmable_clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = 11,
  parameter int DEFAULT_DIV = 2047,
  parameter bit DEFAULT_EN  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic                 cfg_en_i,
  input  logic                 cfg_mode_i,
  input  logic [DIV_WIDTH-1:0] cfg_div_i,
  output logic                 out_o,
  output logic                 tick_o,
  output logic                 pending_o
);

  localparam ch_cfg_t RST_CFG = '{en: DEFAULT_EN, mode: MODE_TOGGLE, div: CFG_DIV_W'(DEFAULT_DIV)};

  ch_cfg_t              act_q, act_d;
  ch_cfg_t              shd_q, shd_d;
  ch_cfg_t              wr_cfg;
  logic                 pend_q, pend_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 tick_q, tick_d;
  logic                 tc;

  assign wr_cfg = '{en: cfg_en_i, mode: cfg_mode_i, div: CFG_DIV_W'(cfg_div_i)};
  assign tc     = act_q.en && (CFG_DIV_W'(cnt_q) == act_q.div);

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (tc && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    // Disabling, or configuring an idle channel, has no period to protect.
    if (we_i) begin
      if (!cfg_en_i || !act_q.en) begin
        act_d  = wr_cfg;
        shd_d  = wr_cfg;
        pend_d = 1'b0;
      end else begin
        shd_d  = wr_cfg;
        pend_d = 1'b1;
      end
    end

    cnt_d  = cnt_q;
    out_d  = out_q;
    tick_d = 1'b0;
    if (!act_q.en || !act_d.en) begin
      cnt_d = '0;
      out_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (act_d.mode != act_q.mode) begin
        out_d = 1'b0;
      end else if (act_q.mode == MODE_PULSE) begin
        out_d = 1'b1;
      end else begin
        out_d = ~out_q;
      end
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
      if (act_q.mode == MODE_PULSE) begin
        out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_q  <= RST_CFG;
      shd_q  <= RST_CFG;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign out_o     = out_q;
  assign tick_o    = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/programmable_clock_divider.sv
// Multi-channel programmable clock divider; decodes the config channel index
// and fans the write out to NUM_CH independent divider channels.
module programmable_clock_divider
  import programmable_clock_divider_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_WIDTH   = 11,
  parameter int  DEFAULT_DIV = 2047,
  parameter bit  DEFAULT_EN  = 1'b1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 IN_50Mhz,
  input  logic                 RESET,
  input  logic                 CFG_WE,
  input  logic [CH_W-1:0]      CFG_CH,
  input  logic [DIV_WIDTH-1:0] CFG_DIV,
  input  logic                 CFG_MODE,
  input  logic                 CFG_EN,
  output logic [NUM_CH-1:0]    OUT,
  output logic [NUM_CH-1:0]    TICK,
  output logic [NUM_CH-1:0]    PENDING
);

  // Exact-match decode: indices at or above NUM_CH select no channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = CFG_WE && (CFG_CH == CH_W'(i));

    divider_channel #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV),
      .DEFAULT_EN (DEFAULT_EN)
    ) u_ch (
      .clk_i     (IN_50Mhz),
      .rst_i     (RESET),
      .we_i      (we_ch),
      .cfg_en_i  (CFG_EN),
      .cfg_mode_i(CFG_MODE),
      .cfg_div_i (CFG_DIV),
      .out_o     (OUT[i]),
      .tick_o    (TICK[i]),
      .pending_o (PENDING[i])
    );
  end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Scoreboard bench: stimulus pushes expected TICK events (cycle, OUT level) per
// channel; a negedge monitor pops and compares whenever a watched channel ticks.
module tb_programmable_clock_divider;

  localparam int NCH  = 5;
  localparam int DW   = 11;
  localparam int CHW  = 3;

  logic           clk;
  logic           RESET;
  logic           CFG_WE;
  logic [CHW-1:0] CFG_CH;
  logic [DW-1:0]  CFG_DIV;
  logic           CFG_MODE;
  logic           CFG_EN;
  logic [NCH-1:0] OUT;
  logic [NCH-1:0] TICK;
  logic [NCH-1:0] PENDING;

  programmable_clock_divider #(
    .NUM_CH     (NCH),
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(2047),
    .DEFAULT_EN (1'b1)
  ) dut (
    .IN_50Mhz(clk),
    .RESET   (RESET),
    .CFG_WE  (CFG_WE),
    .CFG_CH  (CFG_CH),
    .CFG_DIV (CFG_DIV),
    .CFG_MODE(CFG_MODE),
    .CFG_EN  (CFG_EN),
    .OUT     (OUT),
    .TICK    (TICK),
    .PENDING (PENDING)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic out;
  } ev_t;

  ev_t exp_q [NCH][$];
  int  mon_until [NCH] = '{default: 0};
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic push_ev(input int c, input int cy, input logic o);
    ev_t e;
    e.cyc = cy;
    e.out = o;
    exp_q[c].push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: missed events are reported once their cycle has passed.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0].cyc < cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL tick_missing ch%0d: no TICK at cycle %0d, expected one", c, exp_q[c][0].cyc);
        void'(exp_q[c].pop_front());
      end
      if (TICK[c] && cyc <= mon_until[c]) begin
        n_chk++;
        if (exp_q[c].size() > 0 && exp_q[c][0].cyc == cyc) begin
          if (OUT[c] !== exp_q[c][0].out) begin
            n_fail++;
            $display("FAIL tick_out ch%0d at cycle %0d: OUT=%b, expected %b", c, cyc, OUT[c], exp_q[c][0].out);
          end
          void'(exp_q[c].pop_front());
        end else begin
          n_fail++;
          $display("FAIL tick_unexpected ch%0d: TICK at cycle %0d, expected none", c, cyc);
        end
      end
    end
  end

  task automatic to_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic drive(input int ch, input int div, input logic mode, input logic en);
    CFG_WE   = 1'b1;
    CFG_CH   = CHW'(ch);
    CFG_DIV  = DW'(div);
    CFG_MODE = mode;
    CFG_EN   = en;
  endtask

  task automatic idle();
    CFG_WE = 1'b0;
  endtask

  int f;
  int f2;

  initial begin
    RESET = 1'b1; CFG_WE = 1'b0; CFG_CH = '0; CFG_DIV = '0; CFG_MODE = 1'b0; CFG_EN = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out",     32'(OUT),     32'h0);
    check("reset_tick",    32'(TICK),    32'h0);
    check("reset_pending", 32'(PENDING), 32'h0);
    RESET = 1'b0;
    f = cyc + 1;

    // Default channel 0: 2048-clock tick spacing, OUT toggling each tick.
    push_ev(0, f + 2047, 1'b1);
    push_ev(0, f + 4095, 1'b0);
    push_ev(0, f + 6143, 1'b1);
    mon_until[0] = f + 6262;

    // ch1 -> DIV=3 toggle, ch2 -> DIV=0 pulse, both mid-period.
    to_cyc(f + 99);
    drive(1, 3, 1'b0, 1'b1);
    to_cyc(f + 100);
    drive(2, 0, 1'b1, 1'b1);
    check("pending_ch1_set", 32'(PENDING), 32'h02);
    to_cyc(f + 101);
    idle();
    check("pending_ch12_set", 32'(PENDING), 32'h06);
    for (int k = 0; k <= 1050; k++) push_ev(1, f + 2047 + 4 * k, (k % 2 == 0));
    mon_until[1] = f + 6260;
    push_ev(2, f + 2047, 1'b0);
    for (int k = 2048; k <= 2052; k++) push_ev(2, f + k, 1'b1);
    mon_until[2] = f + 2052;

    to_cyc(f + 2046);
    check("pending_before_tc", 32'(PENDING), 32'h06);
    to_cyc(f + 2047);
    check("pending_after_tc", 32'(PENDING), 32'h00);
    to_cyc(f + 2050);
    check("ch2_pulse_out", 32'(OUT[2]), 32'h1);

    // Disable ch0 mid-count while OUT[0] is high, then re-enable with DIV=4.
    to_cyc(f + 6199);
    check("ch0_out_before_dis", 32'(OUT[0]), 32'h1);
    drive(0, 2047, 1'b0, 1'b0);
    to_cyc(f + 6200);
    idle();
    check("ch0_out_disabled",  32'(OUT[0]),  32'h0);
    check("ch0_tick_disabled", 32'(TICK[0]), 32'h0);
    to_cyc(f + 6209);
    drive(0, 4, 1'b0, 1'b1);
    to_cyc(f + 6210);
    idle();
    check("ch0_enable_no_pending", 32'(PENDING[0]), 32'h0);
    for (int k = 0; k < 10; k++) push_ev(0, f + 6215 + 5 * k, (k % 2 == 0));

    // ch1: two writes (second overwrites shadow), then a write on a TC edge.
    to_cyc(f + 6243);
    drive(1, 7, 1'b0, 1'b1);
    to_cyc(f + 6244);
    drive(1, 5, 1'b0, 1'b1);
    check("pending_overwrite", 32'(PENDING), 32'h02);
    to_cyc(f + 6245);
    idle();
    to_cyc(f + 6246);
    drive(1, 1, 1'b0, 1'b1);
    to_cyc(f + 6247);
    idle();
    check("pending_write_at_tc", 32'(PENDING), 32'h02);
    push_ev(1, f + 6253, 1'b0);
    push_ev(1, f + 6255, 1'b1);
    push_ev(1, f + 6257, 1'b0);
    push_ev(1, f + 6259, 1'b1);

    // Out-of-range channel writes must change nothing.
    to_cyc(f + 6249);
    drive(5, 0, 1'b1, 1'b0);
    to_cyc(f + 6250);
    drive(7, 0, 1'b1, 1'b0);
    check("oor_pending_a", 32'(PENDING), 32'h02);
    to_cyc(f + 6251);
    idle();
    check("oor_pending_b", 32'(PENDING), 32'h02);
    to_cyc(f + 6252);
    check("pending_div5_hold", 32'(PENDING), 32'h02);
    to_cyc(f + 6253);
    check("pending_div5_apply", 32'(PENDING), 32'h00);

    // Reset while ch3 has a pending config.
    to_cyc(f + 6299);
    drive(3, 10, 1'b0, 1'b1);
    to_cyc(f + 6300);
    idle();
    check("pending_ch3", 32'(PENDING), 32'h08);
    to_cyc(f + 6305);
    check("ch2_out_pre_reset",  32'(OUT[2]),  32'h1);
    check("ch2_tick_pre_reset", 32'(TICK[2]), 32'h1);
    #3;
    RESET = 1'b1;
    #1;
    check("async_reset_out",     32'(OUT),     32'h0);
    check("async_reset_tick",    32'(TICK),    32'h0);
    check("async_reset_pending", 32'(PENDING), 32'h0);
    repeat (3) @(negedge clk);
    RESET = 1'b0;
    f2 = cyc + 1;
    push_ev(3, f2 + 2047, 1'b1);
    mon_until[3] = f2 + 2050;
    push_ev(2, f2 + 2047, 1'b1);
    mon_until[2] = f2 + 2050;
    to_cyc(f2 + 11);
    check("pending_after_reset", 32'(PENDING), 32'h0);
    to_cyc(f2 + 2052);

    for (int c = 0; c < NCH; c++) begin
      while (exp_q[c].size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL tick_leftover ch%0d: no TICK at cycle %0d, expected one", c, exp_q[c][0].cyc);
        void'(exp_q[c].pop_front());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
